// File: rtl/sequenciador_medidas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sequenciador_medidas_pkg
// Description : Shared state encodings, the BCD measurement type and the
//               default proximity threshold for the measurement scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sequenciador_medidas_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    DISPARA  = 4'd2,
    AGUARDA  = 4'd3,
    ARMAZENA = 4'd4,
    ERRO     = 4'd5
  } estado_t;

  // Three BCD digits: hundreds [11:8], tens [7:4], units [3:0], in cm.
  typedef logic [11:0] medida_bcd_t;

  localparam medida_bcd_t LIMIAR_BCD_PADRAO = 12'h020;

endpackage
`default_nettype wire

// File: rtl/sequenciador_medidas_contador.sv
`default_nettype none
// ============================================================================
// Module      : contador_saturado
// Description : Up-counter with synchronous clear and count enable that
//               stops at MAXIMO; fim is high while the count sits there.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_saturado #(
  parameter int MAXIMO  = 1,
  parameter int LARGURA = $clog2(MAXIMO) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpa,
  input  logic               conta,
  output logic [LARGURA-1:0] valor,
  output logic               fim
);

  localparam logic [LARGURA-1:0] VALOR_MAX = LARGURA'(MAXIMO);

  // Count up until the ceiling, clear has priority over counting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valor <= '0;
    end else if (limpa) begin
      valor <= '0;
    end else if (conta && (valor != VALOR_MAX)) begin
      valor <= valor + LARGURA'(1);
    end
  end

  assign fim = (valor == VALOR_MAX);

endmodule
`default_nettype wire

// File: rtl/sequenciador_medidas.sv
`default_nettype none
// ============================================================================
// Module      : sequenciador_medidas
// Description : Periodic HC-SR04 measurement scheduler. Pulses medir at a
//               fixed cadence, captures the BCD distance on a pronto rising
//               edge, flags proximity and recovers from lost echoes.
//               Optional macro SEQ_CONTADOR_ERROS_EN adds the db_erros port
//               (saturating timeout count).
// Revision    : 1.0 - initial release
// ============================================================================
module sequenciador_medidas
  import sequenciador_medidas_pkg::*;
#(
  parameter int          PERIODO_CICLOS = 5_000_000,
  parameter int          TIMEOUT_CICLOS = 2_500_000,
  parameter int          LARGURA_MEDIR  = 5,
  parameter medida_bcd_t LIMIAR_BCD     = LIMIAR_BCD_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        pronto_sensor,
  input  logic [11:0] medida_sensor,
  output logic        medir,
  output logic [11:0] medida,
  output logic        nova_medida,
  output logic        alerta,
  output logic        timeout,
  output logic [3:0]  db_estado
`ifdef SEQ_CONTADOR_ERROS_EN
  ,
  output logic [7:0]  db_erros
`endif
);

  localparam int LARG_PERIODO = $clog2(PERIODO_CICLOS) + 1;
  localparam int LARG_TIMEOUT = $clog2(TIMEOUT_CICLOS) + 1;
  // The period counter doubles as the medir width timer: it starts at 0 on
  // the first DISPARA cycle.
  localparam logic [LARG_PERIODO-1:0] FIM_MEDIR      = LARG_PERIODO'(LARGURA_MEDIR - 1);
  localparam logic [LARG_TIMEOUT-1:0] LIMITE_TIMEOUT = LARG_TIMEOUT'(TIMEOUT_CICLOS);

  estado_t                 estado;
  estado_t                 proximo;
  logic                    pronto_ant;
  logic                    borda;
  logic                    limpa_periodo;
  logic                    fim_periodo;
  logic                    fim_timeout;
  logic [LARG_PERIODO-1:0] cnt_periodo;
  logic [LARG_TIMEOUT-1:0] cnt_timeout;

  assign borda = pronto_sensor & ~pronto_ant;

  contador_saturado #(
    .MAXIMO  (PERIODO_CICLOS - 1),
    .LARGURA (LARG_PERIODO)
  ) u_periodo (
    .clock (clock),
    .reset (reset),
    .limpa (limpa_periodo),
    .conta (1'b1),
    .valor (cnt_periodo),
    .fim   (fim_periodo)
  );

  contador_saturado #(
    .MAXIMO  (TIMEOUT_CICLOS),
    .LARGURA (LARG_TIMEOUT)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .limpa (estado != AGUARDA),
    .conta (1'b1),
    .valor (cnt_timeout),
    .fim   (fim_timeout)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Next-state logic; the period counter is cleared on the way into DISPARA.
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:  if (ligar) proximo = DISPARA;
      ESPERA: begin
        if (!ligar)           proximo = INICIAL;
        else if (fim_periodo) proximo = DISPARA;
      end
      DISPARA:  if (cnt_periodo == FIM_MEDIR) proximo = AGUARDA;
      AGUARDA: begin
        if (borda)            proximo = ARMAZENA;
        else if (fim_timeout) proximo = ERRO;
      end
      ARMAZENA: proximo = ESPERA;
      ERRO:     proximo = ESPERA;
      default:  proximo = INICIAL;
    endcase
    limpa_periodo = (proximo == DISPARA) && (estado != DISPARA);
  end

  // Capture on a fresh pronto edge; flag a timeout when the wait expires.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pronto_ant <= 1'b0;
      medida     <= '0;
      alerta     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      pronto_ant <= pronto_sensor;
      if (estado == AGUARDA) begin
        if (borda) begin
          medida  <= medida_sensor;
          alerta  <= (medida_sensor < LIMIAR_BCD);
          timeout <= 1'b0;
        end else if (cnt_timeout == LIMITE_TIMEOUT) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  assign medir       = (estado == DISPARA);
  assign nova_medida = (estado == ARMAZENA);
  assign db_estado   = estado;

`ifdef SEQ_CONTADOR_ERROS_EN
  logic [7:0] erros;

  // Count timeouts, sticking at the top value.
  always_ff @(posedge clock) begin
    if (!reset)                                erros <= 8'd0;
    else if (estado == ERRO && erros != 8'hFF) erros <= erros + 8'd1;
  end

  assign db_erros = erros;
`endif

endmodule
`default_nettype wire
